// File: rtl/mul_pkg.sv
// Shared constants and elaboration helpers for the pipelined multiplier.
package mul_pkg;

    localparam logic MUL_UNSIGNED = 1'b0;
    localparam logic MUL_SIGNED   = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    function automatic int MUL_LAT(input int width);
        return clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mul_tree_level.sv
// One registered level of the partial-product adder tree.
module mul_tree_level
    import mul_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int W     = 8,
    parameter int TAG_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic [N_IN-1:0][W-1:0]     in_rows,
    input  logic                       in_valid,
    input  logic [TAG_W-1:0]           in_tag,
    output logic [N_IN/2-1:0][W-1:0]   out_rows,
    output logic                       out_valid,
    output logic [TAG_W-1:0]           out_tag
);

    localparam int N_OUT = N_IN / 2;

    logic [N_OUT-1:0][W-1:0] rows_d, rows_q;
    logic                    valid_d, valid_q;
    logic [TAG_W-1:0]        tag_d, tag_q;

    always_comb begin
        rows_d  = rows_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        if (en) begin
            for (int i = 0; i < N_OUT; i++) begin
                rows_d[i] = in_rows[2*i] + in_rows[2*i+1];
            end
            valid_d = in_valid;
            tag_d   = in_tag;
        end
        // Squash wins over advance: a held stage is also invalidated.
        if (clr) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q  <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            rows_q  <= rows_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign out_rows  = rows_q;
    assign out_valid = valid_q;
    assign out_tag   = tag_q;

endmodule

// File: rtl/mul_pipe_param.sv
// Fully pipelined signed/unsigned multiplier: partial-product stage
// followed by a registered binary adder tree, with stall and flush.
module mul_pipe_param
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int LAT    = MUL_LAT(WIDTH);
    localparam int LEVELS = LAT - 1;
    localparam int PW     = 2 * WIDTH;

    logic stall;
    logic en;
    logic clr;

    logic [PW-1:0]              ext_a;
    logic [WIDTH-1:0][PW-1:0]   rows_d, rows_q;
    logic                       valid_d, valid_q;
    logic [TAG_W-1:0]           tag_d, tag_q;

    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    assign clr      = rst || flush;
    assign in_ready = !stall;

    always_comb begin
        if (in_signed == MUL_UNSIGNED) begin
            ext_a = {{WIDTH{1'b0}}, in_a};
        end else begin
            ext_a = {{WIDTH{in_a[WIDTH-1]}}, in_a};
        end
        rows_d  = rows_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        if (en) begin
            for (int j = 0; j < WIDTH; j++) begin
                rows_d[j] = in_b[j] ? (ext_a << j) : '0;
            end
            // Signed multiplier MSB carries weight -2^(WIDTH-1).
            if (in_signed == MUL_SIGNED && in_b[WIDTH-1]) begin
                rows_d[WIDTH-1] = -(ext_a << (WIDTH - 1));
            end
            valid_d = in_valid;
            tag_d   = in_tag;
        end
        if (clr) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q  <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            rows_q  <= rows_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N_IN = WIDTH >> l;

        logic [N_IN-1:0][PW-1:0]   src_rows;
        logic                      src_valid;
        logic [TAG_W-1:0]          src_tag;
        logic [N_IN/2-1:0][PW-1:0] sum_rows;
        logic                      sum_valid;
        logic [TAG_W-1:0]          sum_tag;

        if (l == 0) begin : g_src
            assign src_rows  = rows_q;
            assign src_valid = valid_q;
            assign src_tag   = tag_q;
        end else begin : g_src
            assign src_rows  = g_lvl[l-1].sum_rows;
            assign src_valid = g_lvl[l-1].sum_valid;
            assign src_tag   = g_lvl[l-1].sum_tag;
        end

        mul_tree_level #(
            .N_IN  (N_IN),
            .W     (PW),
            .TAG_W (TAG_W)
        ) u_lvl (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .clr       (clr),
            .in_rows   (src_rows),
            .in_valid  (src_valid),
            .in_tag    (src_tag),
            .out_rows  (sum_rows),
            .out_valid (sum_valid),
            .out_tag   (sum_tag)
        );
    end

    assign out_p     = g_lvl[LEVELS-1].sum_rows;
    assign out_valid = g_lvl[LEVELS-1].sum_valid;
    assign out_tag   = g_lvl[LEVELS-1].sum_tag;

endmodule

// File: tb/tb_mul_pipe_param.sv
// Random and directed checks of mul_pipe_param at WIDTH=32 and WIDTH=8.
module tb_mul_pipe_param;

    typedef struct packed {
        logic [63:0] p;
        logic [4:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    exp_t q32[$];
    exp_t q8[$];

    logic        w32_rst, w32_flush, w32_iv, w32_ir, w32_sg, w32_ov, w32_or;
    logic [31:0] w32_a, w32_b;
    logic [4:0]  w32_tag, w32_otag;
    logic [63:0] w32_p;

    logic        w8_rst, w8_flush, w8_iv, w8_ir, w8_sg, w8_ov, w8_or;
    logic [7:0]  w8_a, w8_b;
    logic [4:0]  w8_tag, w8_otag;
    logic [15:0] w8_p;

    mul_pipe_param #(.WIDTH(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .rst(w32_rst), .flush(w32_flush),
        .in_valid(w32_iv), .in_ready(w32_ir), .in_signed(w32_sg),
        .in_a(w32_a), .in_b(w32_b), .in_tag(w32_tag),
        .out_valid(w32_ov), .out_ready(w32_or),
        .out_p(w32_p), .out_tag(w32_otag)
    );

    mul_pipe_param #(.WIDTH(8), .TAG_W(5)) u_dut8 (
        .clk(clk), .rst(w8_rst), .flush(w8_flush),
        .in_valid(w8_iv), .in_ready(w8_ir), .in_signed(w8_sg),
        .in_a(w8_a), .in_b(w8_b), .in_tag(w8_tag),
        .out_valid(w8_ov), .out_ready(w8_or),
        .out_p(w8_p), .out_tag(w8_otag)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Mathematical product of the extended operands, truncated to 2*w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic s,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
        longint ea, eb;
        logic [63:0] p;
        int sh;
        sh = 64 - w;
        ea = s ? (longint'(a << sh) >>> sh) : longint'(a);
        eb = s ? (longint'(b << sh) >>> sh) : longint'(b);
        p = ea * eb;
        if (2 * w < 64) p = p & ((64'd1 << (2 * w)) - 64'd1);
        return p;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk_eq("w32 in_ready", w32_ir, !(w32_ov && !w32_or));
            if (w32_ov && w32_or) begin
                if (q32.size() == 0) begin
                    chk_eq("w32 stray result", w32_ov, 1'b0);
                end else begin
                    e = q32.pop_front();
                    chk_eq("w32 p", w32_p, e.p);
                    chk_eq("w32 tag", w32_otag, e.tag);
                end
            end
            if (w32_rst || w32_flush) q32.delete();
            else if (w32_iv && w32_ir)
                q32.push_back('{ref_mul(32, w32_sg, w32_a, w32_b), w32_tag});

            chk_eq("w8 in_ready", w8_ir, !(w8_ov && !w8_or));
            if (w8_ov && w8_or) begin
                if (q8.size() == 0) begin
                    chk_eq("w8 stray result", w8_ov, 1'b0);
                end else begin
                    e = q8.pop_front();
                    chk_eq("w8 p", w8_p, e.p);
                    chk_eq("w8 tag", w8_otag, e.tag);
                end
            end
            if (w8_rst || w8_flush) q8.delete();
            else if (w8_iv && w8_ir)
                q8.push_back('{ref_mul(8, w8_sg, w8_a, w8_b), w8_tag});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op32(input string nm, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t,
                        input logic [63:0] exp);
        int n;
        w32_iv = 1'b1; w32_sg = s; w32_a = a; w32_b = b; w32_tag = t;
        w32_or = 1'b1;
        tick();
        w32_iv = 1'b0;
        n = 1;
        while (!w32_ov && n < 20) begin
            tick();
            n++;
        end
        chk_eq({nm, " latency"}, n, 6);
        chk_eq({nm, " p"}, w32_p, exp);
        chk_eq({nm, " tag"}, w32_otag, t);
        tick();
    endtask

    task automatic drain32();
        int n;
        w32_iv = 1'b0; w32_or = 1'b1;
        n = 0;
        while (q32.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        chk_eq("w32 drained", q32.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic ov_hist [16];
        int i, cyc, acc8;

        w32_rst = 1'b1; w32_flush = 1'b0; w32_iv = 1'b0; w32_sg = 1'b0;
        w32_a = '0; w32_b = '0; w32_tag = '0; w32_or = 1'b1;
        w8_rst = 1'b1; w8_flush = 1'b0; w8_iv = 1'b0; w8_sg = 1'b0;
        w8_a = '0; w8_b = '0; w8_tag = '0; w8_or = 1'b1;
        repeat (2) tick();
        w32_rst = 1'b0;
        w8_rst = 1'b0;
        chk_eq("reset ov32", w32_ov, 1'b0);
        chk_eq("reset p32", w32_p, 64'd0);
        chk_eq("reset tag32", w32_otag, 5'd0);
        chk_eq("reset ov8", w8_ov, 1'b0);
        chk_eq("reset p8", w8_p, 16'd0);
        mon_en = 1'b1;

        op32("s7x-3", 1'b1, 32'd7, 32'hFFFF_FFFD, 5'd3, 64'hFFFF_FFFF_FFFF_FFEB);
        op32("uFFxFF", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,
             64'hFFFF_FFFE_0000_0001);
        op32("sFFxFF", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10,
             64'h0000_0000_0000_0001);
        op32("s80x80", 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd17,
             64'h4000_0000_0000_0000);
        op32("s80x1", 1'b1, 32'h8000_0000, 32'd1, 5'd31,
             64'hFFFF_FFFF_8000_0000);

        // 8 back-to-back ops: results occupy exactly 8 consecutive cycles.
        for (int c = 0; c < 16; c++) begin
            w32_iv = (c < 8); w32_sg = 1'(c); w32_a = $urandom;
            w32_b = $urandom; w32_tag = 5'(c);
            tick();
            ov_hist[c] = w32_ov;
        end
        for (int c = 4; c < 16; c++) chk_eq("b2b out_valid", ov_hist[c], (c >= 5 && c <= 12));
        drain32();

        i = 0; cyc = 0;
        while (i < 8 && cyc < 100) begin
            w32_iv = 1'b1; w32_sg = $urandom; w32_a = $urandom;
            w32_b = $urandom; w32_tag = 5'(i + 8);
            w32_or = !(cyc >= 7 && cyc < 10);
            @(negedge clk);
            if (cyc == 8) chk_eq("stall in_ready", w32_ir, 1'b0);
            if (w32_ir) i++;
            tick();
            cyc++;
        end
        chk_eq("stall accepted", i, 8);
        drain32();

        // Four in flight plus one offered on the flush cycle.
        for (int c = 0; c < 5; c++) begin
            w32_iv = 1'b1; w32_sg = 1'b0; w32_a = $urandom; w32_b = $urandom;
            w32_tag = 5'(c); w32_flush = (c == 4);
            tick();
        end
        w32_flush = 1'b0; w32_iv = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk_eq("flush quiet", w32_ov, 1'b0);
            tick();
        end
        op32("after flush", 1'b1, 32'hFFFF_FF00, 32'd5, 5'd21, 64'hFFFF_FFFF_FFFF_FB00);

        for (int c = 0; c < 3; c++) begin
            w32_iv = 1'b1; w32_a = $urandom; w32_b = $urandom; w32_tag = 5'(c);
            tick();
        end
        w32_iv = 1'b0; w32_rst = 1'b1;
        tick();
        w32_rst = 1'b0;
        chk_eq("rst mid ov", w32_ov, 1'b0);
        repeat (8) tick();

        w32_or = 1'b0;
        for (int c = 0; c < 8; c++) begin
            w32_iv = 1'b1; w32_a = $urandom; w32_b = $urandom; w32_tag = 5'(c);
            tick();
        end
        chk_eq("stalled full", w32_ov, 1'b1);
        w32_iv = 1'b0; w32_rst = 1'b1;
        tick();
        w32_rst = 1'b0;
        chk_eq("rst stall ov", w32_ov, 1'b0);
        chk_eq("rst stall p", w32_p, 64'd0);
        chk_eq("rst stall tag", w32_otag, 5'd0);
        w32_or = 1'b1;
        repeat (8) tick();
        op32("after rst", 1'b0, 32'd12345, 32'd678, 5'd7, 64'd8369910);

        acc8 = 0; cyc = 0;
        while (acc8 < 1000 && cyc < 20000) begin
            w8_iv = ($urandom_range(0, 9) < 8);
            w8_sg = 1'($urandom); w8_a = 8'($urandom); w8_b = 8'($urandom);
            w8_tag = 5'($urandom); w8_or = ($urandom_range(0, 3) != 0);
            w8_flush = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            if (w8_iv && w8_ir && !w8_flush) acc8++;
            tick();
            cyc++;
        end
        chk_eq("w8 accepted", acc8, 1000);
        w8_iv = 1'b0; w8_flush = 1'b0; w8_or = 1'b1;
        cyc = 0;
        while (q8.size() != 0 && cyc < 30) begin
            tick();
            cyc++;
        end
        chk_eq("w8 drained", q8.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_pipe_param.md
Name: mul_pipe_param

Overview:
- Parametrised, fully pipelined integer multiplier for the CPU's MULT/MULTU path, one result per cycle.
- Each operation selects signed or unsigned mode; data width is set by a parameter.
- A valid/ready handshake with backpressure carries each operation through the pipeline together with a destination tag.
- A flush input squashes in-flight operations on exception or branch mispredict.

Parameters:
- WIDTH, 32, operand width; power of 2, 4..64.
- TAG_W, 5, width of the sideband tag (destination/HI-LO id) carried with each operation.
- LAT, derived = clog2(WIDTH)+1, pipeline latency in cycles; a localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  squash all in-flight operations.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_signed  in  1  1 = signed (MULT), 0 = unsigned (MULTU).
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result when out_valid && out_ready.
- out_p  out  2*WIDTH  product.
- out_tag  out  TAG_W  tag of the operation in out_p.

Behaviour:
- Reset: on a clk edge with rst=1, every stage valid bit clears. out_valid=0, out_p=0, out_tag=0. Data registers may also clear. rst overrides flush and all inputs.
- Arithmetic:
  - out_p = (ext(a) * ext(b)) mod 2^(2*WIDTH).
  - ext = sign-extension if in_signed, else zero-extension.
  - in_signed is captured with the operands and used only by stage 1.
- Stage 1: forms WIDTH partial-product rows, each 2*WIDTH bits.
  - Row j for j<WIDTH-1: b[j] ? ext(a)<<j : 0.
  - Row WIDTH-1: b[WIDTH-1] ? (in_signed ? -(ext(a)<<(WIDTH-1)) : ext(a)<<(WIDTH-1)) : 0.
- Stages 2..LAT: registered binary adder tree. Each level halves the row count with pairwise 2*WIDTH-bit adds, so there are clog2(WIDTH) levels. The final sum is out_p.
- Latency: an operation accepted on edge k with no stall appears with out_valid=1 after edge k+LAT-1, i.e. LAT cycles of pipeline.
  - WIDTH=32 gives LAT=6.
  - Throughput is 1 op per cycle.
- Each stage holds a valid bit and tag alongside its data.
- Backpressure:
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stall=1, all stages (data, tag, valid) hold. No bubble compression is required.
  - While stall=0, all stages advance. Stage 1 loads the input and its valid = in_valid.
- in_ready depends combinationally on out_ready. No combinational path from in_* to out_*.
- Bubbles: an invalid stage's data is don't-care. out_p/out_tag are only meaningful when out_valid=1.
- Flush: on an edge with flush=1, all stage valid bits (including the output) clear.
  - An operation offered in the same cycle is dropped, even if in_ready=1.
  - Flush takes effect regardless of stall.
  - Data registers need not clear.
- Simultaneous out-handshake and new input: both occur; the pipeline advances one stage.
- out_valid/out_p/out_tag are driven directly from the last stage registers.

Decomposition:
- Package mul_pkg:
  - clog2 function.
  - MUL_LAT(width) function.
  - Mode constants MUL_UNSIGNED=0, MUL_SIGNED=1.
- One sub-module, mul_tree_level, instantiated clog2(WIDTH) times via generate:
  - Parameters N_IN and W.
  - Registers pairwise sums of N_IN rows into N_IN/2 rows, plus valid and tag.
  - Has en (=!stall), clr (=rst|flush, valid only) and rst ports.

Test Plan:
- WIDTH=32, signed, a=7, b=0xFFFFFFFD (-3) -> after 6 cycles out_p=0xFFFFFFFF_FFFFFFEB, out_tag echoes in_tag.
- Unsigned a=b=0xFFFFFFFF -> out_p=0xFFFFFFFE_00000001. Same operands signed -> out_p=0x00000000_00000001.
- Signed a=b=0x80000000 -> out_p=0x40000000_00000000. Signed a=0x80000000, b=1 -> 0xFFFFFFFF_80000000.
- Back-to-back: 8 ops on consecutive cycles with out_ready=1 -> 8 consecutive out_valid cycles, in order, correct tags. Then hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during those cycles, no result lost or duplicated, order preserved.
- Flush with 4 ops in flight plus one offered that cycle -> out_valid stays 0 for the next 6 cycles. The next accepted op returns normally after LAT.
- Assert rst for one cycle mid-stream, including while stalled -> out_valid=0 next cycle and no stale result ever emerges. Sweep WIDTH=8 (LAT=4) with 1000 random signed/unsigned ops against a reference model.
